// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the fetch path: increment, relative/absolute
// jumps, call/return through an internal return-address stack, stall and fault.
module pc_sequencer #(
    parameter int              PC_W        = 8,
    parameter int              OFF_W       = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int             DW          = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             jump_rel,
    input  logic             jump_abs,
    input  logic             call,
    input  logic             ret,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [DW-1:0]    depth,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             fault
);

    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0] pc_q, pc_d;
    logic [DW-1:0]   depth_q, depth_d;
    logic            fault_q, fault_d;
    logic            push;
    logic [PC_W-1:0] stack_q [STACK_DEPTH];

    logic [PC_W-1:0] off_ext;
    logic [PC_W-1:0] pc_inc;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   pop_idx;
    logic            is_empty;
    logic            is_full;

    assign off_ext  = PC_W'($signed(offset));
    assign pc_inc   = pc_q + PC_W'(1);
    assign push_idx = IW'(depth_q);
    assign pop_idx  = IW'(depth_q - DW'(1));
    assign is_empty = (depth_q == '0);
    assign is_full  = (depth_q == DW'(STACK_DEPTH));

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push    = 1'b0;
        // Stall and a latched fault both freeze every piece of state.
        if (!stall && !fault_q) begin
            if (ret) begin
                if (is_empty) begin
                    fault_d = 1'b1;
                end else begin
                    pc_d    = stack_q[pop_idx];
                    depth_d = depth_q - DW'(1);
                end
            end else if (call) begin
                if (is_full) begin
                    fault_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    pc_d    = pc_q + off_ext;
                    depth_d = depth_q + DW'(1);
                end
            end else if (jump_abs) begin
                pc_d = target;
            end else if (jump_rel) begin
                pc_d = pc_q + off_ext;
            end else begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            depth_q <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            fault_q <= fault_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign pc          = pc_q;
    assign depth       = depth_q;
    assign stack_empty = is_empty;
    assign stack_full  = is_full;
    assign fault       = fault_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random
// requests, checked against a queue-based model of the sequencer.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       stall = 1'b0;
    logic       jump_rel = 1'b0;
    logic       jump_abs = 1'b0;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic [7:0] offset = '0;
    logic [7:0] target = '0;
    logic [7:0] pc;
    logic [2:0] depth;
    logic       stack_empty;
    logic       stack_full;
    logic       fault;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .stall(stall),
        .jump_rel(jump_rel), .jump_abs(jump_abs),
        .call(call), .ret(ret), .offset(offset), .target(target),
        .pc(pc), .depth(depth), .stack_empty(stack_empty),
        .stack_full(stack_full), .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pc;
        int depth;
        int fault;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: pc as an integer, return stack as a queue.
    int   m_pc = 0;
    int   m_stk[$];
    int   m_fault = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int wrap(input int v);
        return ((v % 256) + 256) % 256;
    endfunction

    function automatic void model_step(input bit s, jr, ja, c, r,
                                       input logic [7:0] off,
                                       input logic [7:0] tgt);
        int so;
        so = (off > 127) ? int'(off) - 256 : int'(off);
        if (s || m_fault != 0) return;
        if (r) begin
            if (m_stk.size() == 0) m_fault = 1;
            else m_pc = m_stk.pop_back();
        end else if (c) begin
            if (m_stk.size() == 4) m_fault = 1;
            else begin
                m_stk.push_back(wrap(m_pc + 1));
                m_pc = wrap(m_pc + so);
            end
        end else if (ja) begin
            m_pc = int'(tgt);
        end else if (jr) begin
            m_pc = wrap(m_pc + so);
        end else begin
            m_pc = wrap(m_pc + 1);
        end
    endfunction

    task automatic drive(input bit s, jr, ja, c, r,
                         input logic [7:0] off, input logic [7:0] tgt);
        exp_t e;
        @(negedge clk);
        stall = s; jump_rel = jr; jump_abs = ja;
        call = c; ret = r; offset = off; target = tgt;
        model_step(s, jr, ja, c, r, off, tgt);
        e.pc = m_pc;
        e.depth = m_stk.size();
        e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    endtask

    // Asserted between edges; effect must be visible before the next edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        stall = 0; jump_rel = 0; jump_abs = 0; call = 0; ret = 0;
        #1;
        chk("reset_pc", pc, 0);
        chk("reset_depth", depth, 0);
        chk("reset_empty", stack_empty, 1);
        chk("reset_full", stack_full, 0);
        chk("reset_fault", fault, 0);
        m_pc = 0;
        m_stk.delete();
        m_fault = 0;
        @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc", pc, e.pc);
                chk("depth", depth, e.depth);
                chk("empty", stack_empty, e.depth == 0);
                chk("full", stack_full, e.depth == 4);
                chk("fault", fault, e.fault);
            end
        end
    end

    initial begin : stim
        int guard;
        do_reset();
        // sequential run and wrap
        repeat (4) idle();
        drive(0, 0, 1, 0, 0, 8'h00, 8'd255);
        idle();
        // relative jumps
        drive(0, 0, 1, 0, 0, 8'h00, 8'd10);
        drive(0, 1, 0, 0, 0, 8'hFB, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00, 8'd200);
        drive(0, 1, 0, 0, 0, 8'h7F, 8'h00);
        // call / return
        drive(0, 0, 1, 0, 0, 8'h00, 8'd3);
        drive(0, 0, 0, 1, 0, 8'd7, 8'h00);
        drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
        // overflow
        do_reset();
        repeat (5) drive(0, 0, 0, 1, 0, 8'd2, 8'h00);
        drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
        drive(0, 0, 1, 0, 0, 8'h00, 8'd77);
        do_reset();
        // underflow then priority
        drive(0, 0, 0, 0, 1, 8'h00, 8'h00);
        do_reset();
        drive(0, 1, 1, 1, 0, 8'd5, 8'd99);
        // stall, then reset between edges
        repeat (3) drive(1, 1, 0, 0, 0, 8'd3, 8'h00);
        idle();
        do_reset();
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if ((m_fault != 0 && $urandom_range(3) == 0) ||
                $urandom_range(99) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(7) == 0, $urandom_range(3) == 0,
                      $urandom_range(7) == 0, $urandom_range(4) == 0,
                      $urandom_range(5) == 0,
                      8'($urandom), 8'($urandom));
            end
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
